fir_channel_scheduler: RTL
==========================

# fir_channel_scheduler

Time-multiplexed serial FIR engine shared by `N_CH` sample streams. Arbitrates among channel requesters, keeps one circular delay line per channel and one shared coefficient bank, and sequences a single multiply-accumulate unit over `N_TAPS` cycles per accepted sample. It sits between the per-channel sample sources and downstream consumers, and replaces per-channel `serial` FIR instances where area matters more than throughput.

## Interface
Parameters:
- `N_TAPS`, 21: filter length, also the delay-line depth per channel.
- `DATA_WIDTH`, 16: signed sample width.
- `COEF_WIDTH`, 16: signed coefficient width.
- `OUT_WIDTH`, 37: accumulator and output width.
- `N_CH`, 2: number of requesting channels (≥2).
- Derived widths: `CH_W` = max(1, clog2(`N_CH`)); `TAP_W` = clog2(`N_TAPS`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_x_in`  in  `N_CH*DATA_WIDTH`  channel i sample at bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
- `ch_valid`  in  `N_CH`  per-channel sample request.
- `ch_ready`  out  `N_CH`  one-hot grant, combinational; a transfer occurs when valid and ready are both high at an edge.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  `TAP_W`  tap index being written.
- `coef_wdata`  in  `COEF_WIDTH`  signed coefficient.
- `y_out`  out  `OUT_WIDTH`  signed filter result, registered.
- `y_ch`  out  `CH_W`  channel that produced `y_out`.
- `y_valid`  out  1  single-cycle result strobe.
- `busy`  out  1  high while the state is MAC.

## Operation
- Two states: IDLE and MAC.
- IDLE:
  - If any `ch_valid` is high, `ch_ready` is raised for exactly one channel, chosen by the policy under Configuration.
  - At the transfer edge: the sample is written to `dline[ch][wr_ptr[ch]]`, then `wr_ptr[ch]` advances modulo `N_TAPS` (wrapping from `N_TAPS-1` to 0). The granted channel is latched, `acc` and `tap` are set to 0, and the state becomes MAC.
- MAC, one tap per cycle:
  - `acc += coef[tap] * dline[ch][(newest - tap) mod N_TAPS]`, where `newest` is the slot written at acceptance. Tap 0 is the newest sample; the index wraps by adding `N_TAPS` when negative.
  - `tap` increments each cycle.
  - On the `tap == N_TAPS-1` edge: `y_out` takes the final sum, `y_ch` takes the latched channel, `y_valid` is set to 1, and the state returns to IDLE.
- `ch_ready` is all-zero in MAC. A requester holding `ch_valid` waits with no data loss. Dropping `ch_valid` before a grant has no effect.
- Arithmetic:
  - Full-precision signed product of `DATA_WIDTH+COEF_WIDTH` bits, sign-extended to `OUT_WIDTH`.
  - The accumulator wraps modulo 2^`OUT_WIDTH`. With defaults (32 + 5 bits) it cannot overflow.
- Coefficient writes:
  - Accepted only in IDLE, with `coef_addr < N_TAPS`.
  - Writes while `busy`, or with an out-of-range address, are silently dropped.
  - One bank is shared by all channels.
- Reset (asynchronous, any time, including mid-MAC):
  - State goes to IDLE; `acc`, `tap`, all `wr_ptr` values, all delay lines and all coefficients go to 0.
  - Outputs: `y_out`=0, `y_ch`=0, `y_valid`=0, `busy`=0, `ch_ready`=0 while `rst_n` is low.
  - The round-robin pointer is set so that channel 0 wins first.
  - An in-flight result is discarded; no `y_valid` is issued for it.

## Timing
- Acceptance at edge E0. The MAC runs on edges E1..E`N_TAPS`. `y_valid` is high for the one cycle after edge E`N_TAPS` (latency `N_TAPS` clocks).
- Earliest next acceptance is edge E`N_TAPS`+1. Aggregate throughput is one sample per `N_TAPS+1` clocks across all channels (22 with defaults).
- `y_valid` is never high on two consecutive cycles.
- `ch_ready` depends combinationally on `ch_valid` and state only; it has no path from `ch_x_in`.

## Configuration
- `FIR_SCHED_RR_EN` defined: round-robin arbitration. Search starts at the channel after the last granted one; a channel that has just been served has lowest priority.
- `FIR_SCHED_RR_EN` undefined: fixed priority, where the lowest channel index wins. Starvation of higher indices is permitted.

## Test plan
- Impulse: load `coef[k]=k+1`; on ch0 send 1000 followed by zeros. Required: successive ch0 results are 1000, 2000, …, 21000, then 0. `y_ch`=0, and `y_valid` rises 21 clocks after each acceptance.
- Channel isolation: with the impulse on ch0 interleaved with a constant 100 on ch1, ch1 result n equals 100·(n+1)(n+2)/2 for n<21, then 23100. The ch0 sequence is unchanged from the impulse case.
- Arbitration: hold `ch_valid`=2'b11 continuously. With `FIR_SCHED_RR_EN`, grants alternate 0,1,0,1 with acceptances 22 clocks apart. Without it, every grant goes to ch0.
- Extremes: all coefficients and all 21 samples set to -32768. Required: `y_out` = 22548578304 with no wrap.
- Coefficient guard: issue `coef_we` to address 3 while `busy`, and to address 25 while idle. Required: both writes are dropped, and the impulse response still shows the old `coef[3]`.
- Reset mid-MAC: pull `rst_n` low at tap 10. Required: `y_out`=0 and `y_valid`=0 immediately; no result is emitted for that sample; after release, an impulse yields all-zero results because the coefficients were cleared.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Time-multiplexed serial FIR shared by N_CH sample streams: one MAC, per-channel delay lines.
// Define FIR_SCHED_RR_EN for round-robin arbitration; otherwise lowest channel index wins.
module fir_channel_scheduler #(
  parameter int unsigned N_TAPS     = 21,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned COEF_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 37,
  parameter int unsigned N_CH       = 2,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned TAP_W     = $clog2(N_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CH*DATA_WIDTH-1:0]   ch_x_in,
  input  logic [N_CH-1:0]              ch_valid,
  output logic [N_CH-1:0]              ch_ready,
  input  logic                         coef_we,
  input  logic [TAP_W-1:0]             coef_addr,
  input  logic [COEF_WIDTH-1:0]        coef_wdata,
  output logic [OUT_WIDTH-1:0]         y_out,
  output logic [CH_W-1:0]              y_ch,
  output logic                         y_valid,
  output logic                         busy
);

  localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;

  typedef enum logic [0:0] {StIdle, StMac} state_e;

  state_e                         state_q, state_d;
  logic signed [DATA_WIDTH-1:0]   dline_q [N_CH][N_TAPS];
  logic [TAP_W-1:0]               wr_ptr_q [N_CH];
  logic signed [COEF_WIDTH-1:0]   coef_q [N_TAPS];
  logic [CH_W-1:0]                ch_q;
  logic [TAP_W-1:0]               tap_q;
  logic [TAP_W-1:0]               newest_q;
  logic signed [OUT_WIDTH-1:0]    acc_q;
  logic [OUT_WIDTH-1:0]           y_out_q;
  logic [CH_W-1:0]                y_ch_q;
  logic                           y_valid_q;
`ifdef FIR_SCHED_RR_EN
  logic [CH_W-1:0]                rr_q;
`endif

  logic [CH_W-1:0]                grant_ch;
  logic                           found;
  logic                           accept;
  logic                           mac_last;
  logic [TAP_W-1:0]               rd_idx;
  logic signed [PROD_W-1:0]       prod;
  logic signed [OUT_WIDTH-1:0]    prod_ext;
  logic signed [OUT_WIDTH-1:0]    acc_sum;

  // Arbitration sees only ch_valid and state, never sample data.
  always_comb begin
    grant_ch = '0;
    found    = 1'b0;
`ifdef FIR_SCHED_RR_EN
    for (int unsigned i = 0; i < N_CH; i++) begin
      int unsigned cand;
      cand = (32'(rr_q) + 1 + i) % N_CH;
      if (!found && ch_valid[cand]) begin
        found    = 1'b1;
        grant_ch = CH_W'(cand);
      end
    end
`else
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        found    = 1'b1;
        grant_ch = CH_W'(i);
      end
    end
`endif
  end

  assign accept   = (state_q == StIdle) && found;
  assign mac_last = (state_q == StMac) && (tap_q == TAP_W'(N_TAPS - 1));
  assign ch_ready = (rst_n && accept) ? (N_CH'(1) << grant_ch) : '0;

  // Tap 0 is the newest sample; older taps walk backwards around the circular line.
  always_comb begin
    if (newest_q >= tap_q) begin
      rd_idx = newest_q - tap_q;
    end else begin
      rd_idx = TAP_W'({1'b0, newest_q} + (TAP_W + 1)'(N_TAPS) - {1'b0, tap_q});
    end
    prod     = dline_q[ch_q][rd_idx] * coef_q[tap_q];
    prod_ext = OUT_WIDTH'(prod);
    acc_sum  = acc_q + prod_ext;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StMac;
      StMac:   if (mac_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        wr_ptr_q[c] <= '0;
        for (int t = 0; t < int'(N_TAPS); t++) dline_q[c][t] <= '0;
      end
      for (int t = 0; t < int'(N_TAPS); t++) coef_q[t] <= '0;
      ch_q      <= '0;
      tap_q     <= '0;
      newest_q  <= '0;
      acc_q     <= '0;
      y_out_q   <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (accept) begin
        dline_q[grant_ch][wr_ptr_q[grant_ch]] <=
            ch_x_in[int'(grant_ch)*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr_q[grant_ch] <= (wr_ptr_q[grant_ch] == TAP_W'(N_TAPS - 1)) ? '0
                                                                          : wr_ptr_q[grant_ch] + 1'b1;
        newest_q <= wr_ptr_q[grant_ch];
        ch_q     <= grant_ch;
        acc_q    <= '0;
        tap_q    <= '0;
      end
      if (state_q == StMac) begin
        acc_q <= acc_sum;
        tap_q <= tap_q + 1'b1;
      end
      if (mac_last) begin
        y_out_q   <= acc_sum;
        y_ch_q    <= ch_q;
        y_valid_q <= 1'b1;
      end
      if (coef_we && (state_q == StIdle) && (32'(coef_addr) < N_TAPS)) begin
        coef_q[coef_addr] <= coef_wdata;
      end
    end
  end

`ifdef FIR_SCHED_RR_EN
  // Reset value makes channel 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= CH_W'(N_CH - 1);
    end else if (accept) begin
      rr_q <= grant_ch;
    end
  end
`endif

  assign y_out   = y_out_q;
  assign y_ch    = y_ch_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == StMac);

endmodule
